// File: rtl/puzzle_pkg.sv
// Shared types and constants for the 8-puzzle move sequencer and its ALU.
// The opcode values must match the ALU's own decode.
package puzzle_pkg;

  localparam int TILE_W  = 4;
  localparam int BOARD_W = 36;
  localparam int NUM_POS = 9;

  typedef enum logic [3:0] {
    OP_NOP      = 4'd0,
    OP_TO_UP    = 4'd1,
    OP_TO_DOWN  = 4'd2,
    OP_TO_LEFT  = 4'd3,
    OP_TO_RIGHT = 4'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_CHECK = 2'd3
  } state_e;

  function automatic alu_op_e dir_to_op(input dir_e dir);
    case (dir)
      DIR_UP:   return OP_TO_UP;
      DIR_DOWN: return OP_TO_DOWN;
      DIR_LEFT: return OP_TO_LEFT;
      default:  return OP_TO_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/move_legal_chk.sv
// Combinational legality check for moving the blank one step on the 3x3 grid.
// Kept standalone so a future solver can share it.
module move_legal_chk
  import puzzle_pkg::*;
(
  input  logic [TILE_W-1:0] pos,
  input  dir_e              dir,
  output logic              legal
);

  always_comb begin
    case (dir)
      DIR_UP:   legal = (pos >= 4'd3);
      DIR_DOWN: legal = (pos <= 4'd5);
      DIR_LEFT: legal = ((pos % 4'd3) != 4'd0);
      default:  legal = ((pos % 4'd3) != 4'd2);
    endcase
  end

endmodule

// File: rtl/puzzle_move_ctrl.sv
// Board/blank holder and move sequencer: loads a board, validates each move,
// drives the tile-swap ALU for legal ones and tracks solved/limit status.
module puzzle_move_ctrl
  import puzzle_pkg::*;
#(
  parameter int                 MAX_MOVES = 31,
  parameter logic [BOARD_W-1:0] GOAL      = 36'h123456780
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_valid,
  output logic                             load_ready,
  input  logic [BOARD_W-1:0]               load_board,
  input  logic [TILE_W-1:0]                load_blank,
  input  logic                             mv_valid,
  output logic                             mv_ready,
  input  logic [1:0]                       mv_dir,
  output logic [3:0]                       alu_op,
  output logic [TILE_W-1:0]                alu_pos,
  output logic [BOARD_W-1:0]               alu_board,
  input  logic [BOARD_W-1:0]               alu_res_board,
  input  logic [TILE_W-1:0]                alu_res_pos,
  output logic [BOARD_W-1:0]               board,
  output logic [TILE_W-1:0]                blank,
  output logic [$clog2(MAX_MOVES+1)-1:0]   move_cnt,
  output logic                             solved,
  output logic                             limit,
  output logic                             illegal,
  output logic                             load_err
);

  localparam int CW = $clog2(MAX_MOVES + 1);

  state_e               state_q, state_d;
  logic [BOARD_W-1:0]   board_q, board_d;
  logic [TILE_W-1:0]    blank_q, blank_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 solved_q, solved_d;
  logic                 limit_q, limit_d;
  dir_e                 dir_q, dir_d;
  logic                 illegal_q, illegal_d;
  logic                 load_err_q, load_err_d;
  alu_op_e              alu_op_w;
  logic                 mv_legal;

  move_legal_chk u_legal (
    .pos   (blank_q),
    .dir   (dir_q),
    .legal (mv_legal)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    blank_d    = blank_q;
    cnt_d      = cnt_q;
    solved_d   = solved_q;
    limit_d    = limit_q;
    dir_d      = dir_q;
    illegal_d  = 1'b0;
    load_err_d = 1'b0;
    alu_op_w   = OP_NOP;
    load_ready = (state_q == S_IDLE) || (state_q == S_WAIT);
    // A pending load always pre-empts a move in the same cycle.
    mv_ready   = (state_q == S_WAIT) && !solved_q && !limit_q && !load_valid;

    case (state_q)
      S_IDLE, S_WAIT: begin
        if (load_valid) begin
          if (load_blank <= 4'(NUM_POS - 1)) begin
            board_d  = load_board;
            blank_d  = load_blank;
            cnt_d    = '0;
            solved_d = 1'b0;
            limit_d  = 1'b0;
            state_d  = S_CHECK;
          end else begin
            load_err_d = 1'b1;
          end
        end else if (mv_valid && mv_ready) begin
          dir_d   = dir_e'(mv_dir);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (mv_legal) begin
          alu_op_w = dir_to_op(dir_q);
          board_d  = alu_res_board;
          blank_d  = alu_res_pos;
          if (cnt_q != CW'(MAX_MOVES)) cnt_d = cnt_q + CW'(1);
          state_d  = S_CHECK;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_CHECK: begin
        solved_d = (board_q == GOAL);
        limit_d  = (cnt_q == CW'(MAX_MOVES));
        state_d  = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      board_q    <= '0;
      blank_q    <= '0;
      cnt_q      <= '0;
      solved_q   <= 1'b0;
      limit_q    <= 1'b0;
      dir_q      <= DIR_UP;
      illegal_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      blank_q    <= blank_d;
      cnt_q      <= cnt_d;
      solved_q   <= solved_d;
      limit_q    <= limit_d;
      dir_q      <= dir_d;
      illegal_q  <= illegal_d;
      load_err_q <= load_err_d;
    end
  end

  assign alu_op    = alu_op_w;
  assign alu_pos   = blank_q;
  assign alu_board = board_q;
  assign board     = board_q;
  assign blank     = blank_q;
  assign move_cnt  = cnt_q;
  assign solved    = solved_q;
  assign limit     = limit_q;
  assign illegal   = illegal_q;
  assign load_err  = load_err_q;

endmodule

// File: doc/puzzle_move_ctrl.md
# puzzle_move_ctrl

Sequencer for the 8-puzzle tile-swap ALU. It holds the current board and blank position, accepts a loaded board and then a stream of move commands, and rejects illegal moves. For each legal move it drives the ALU's move operation and captures the result. After every load or move it compares the board against the goal and counts moves up to a step limit.

## Interface
- `MAX_MOVES`, default 31: move-count ceiling; `CW = $clog2(MAX_MOVES+1)`.
- `GOAL`, default 36'h123456780: goal board; position 0 at [35:32], position 8 at [3:0], 0 = blank.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_valid` / `load_ready` in / out 1: board-load handshake.
- `load_board` in 36: nine 4-bit tiles.
- `load_blank` in 4: blank position, 0..8.
- `mv_valid` / `mv_ready` in / out 1: move-command handshake.
- `mv_dir` in 2: 0 = UP, 1 = DOWN, 2 = LEFT, 3 = RIGHT.
- `alu_op` out 4: ALU opcode.
- `alu_pos` out 4: to ALU in0.
- `alu_board` out 36: to ALU in1.
- `alu_res_board` in 36: ALU board result, combinational.
- `alu_res_pos` in 4: ALU new blank position, combinational.
- `board` out 36: current board.
- `blank` out 4: current blank position.
- `move_cnt` out CW: legal moves since last load.
- `solved` out 1: level; board == GOAL.
- `limit` out 1: level; move_cnt == MAX_MOVES.
- `illegal` out 1: one-cycle pulse; a move was rejected.
- `load_err` out 1: one-cycle pulse; a load was rejected.

## Operation
- States: S_IDLE (no board), S_WAIT (board held), S_EXEC (ALU driven), S_CHECK (goal compare).
- `load_ready` = 1 in S_IDLE and S_WAIT. It is 0 in S_EXEC and S_CHECK.
- Load accepted with `load_blank` ≤ 8:
  - board and blank are registered;
  - move_cnt, solved and limit are cleared;
  - next state is S_CHECK.
- Load accepted with `load_blank` > 8:
  - `load_err` pulses;
  - no state is changed.
- `mv_ready` = 1 only in S_WAIT with `!solved && !limit`. If load and move are both valid in S_WAIT, the load wins and `mv_ready` is 0 that cycle.
- An accepted move registers `mv_dir` and goes to S_EXEC.
- S_EXEC legality rules, with p = blank:
  - UP is illegal if p < 3;
  - DOWN is illegal if p > 5;
  - LEFT is illegal if p mod 3 = 0;
  - RIGHT is illegal if p mod 3 = 2.
- Illegal move:
  - `alu_op` stays OP_NOP;
  - `illegal` pulses;
  - board and move_cnt are unchanged;
  - next state is S_WAIT.
- Legal move:
  - drive `alu_op` = OP_TO_UP/DOWN/LEFT/RIGHT, `alu_pos` = blank, `alu_board` = board;
  - at the end of the cycle, capture `alu_res_board`/`alu_res_pos` into board/blank;
  - increment move_cnt;
  - next state is S_CHECK.
- S_CHECK:
  - set solved = (board == GOAL);
  - set limit = (move_cnt == MAX_MOVES);
  - next state is S_WAIT.
- Outside S_EXEC: `alu_op` = OP_NOP, `alu_pos` = blank, `alu_board` = board.
- move_cnt never wraps. `limit` blocks further moves, and only a load clears it.

## Timing
- Reset values: state S_IDLE; every output is 0 except `load_ready` = 1.
- Reset asserted mid-operation aborts the in-flight move; no partial board update occurs.
- Load accepted at cycle N: S_CHECK at N+1; solved/limit valid and state S_WAIT at N+2.
- Legal move accepted at N:
  - N+1: S_EXEC, ALU driven; capture at the end of N+1;
  - N+2: board/blank/move_cnt updated, S_CHECK;
  - N+3: solved/limit valid, `mv_ready` may rise.
- Move throughput: one legal move per 3 cycles.
- Illegal move accepted at N: `illegal` high during N+2, S_WAIT at N+2.
- The ALU result must settle within one cycle (combinational path).

## Structure
- Shared package `puzzle_pkg` holds:
  - opcodes OP_NOP (0), OP_TO_UP, OP_TO_DOWN, OP_TO_LEFT, OP_TO_RIGHT, matching the ALU encoding;
  - the direction enum;
  - the state enum;
  - the tile and board widths (4, 36).
- Sub-module `move_legal_chk`: combinational (pos, dir) → legal. Reused by a future solver.

## Test plan
- Reset check: after reset, all outputs are 0 and `load_ready` = 1.
- Goal load: load 36'h123456780 with blank 8 → at N+2 `solved` = 1, `mv_ready` = 0, move_cnt = 0.
- Single winning move: load 36'h123456708 with blank 7, send RIGHT → at N+1 `alu_op` = OP_TO_RIGHT, `alu_pos` = 7. With a bench ALU model, at N+2 board = 36'h123456780, blank = 8, move_cnt = 1. At N+3 `solved` = 1.
- Illegal move: load 36'h012345678 with blank 0, send UP → `illegal` pulses at N+2, `alu_op` is never non-NOP, board and move_cnt are unchanged. LEFT behaves the same.
- Move limit: with MAX_MOVES = 4, blank 4, send RIGHT, LEFT, RIGHT, LEFT → `limit` = 1 and `mv_ready` = 0. A fifth `mv_valid` is not accepted; a reload clears `limit`.
- Load error and reset abort:
  - load with blank 4'd9 → `load_err` pulses and the state remains S_IDLE;
  - assert `rst_n` low during S_EXEC → all outputs return to reset values immediately.
